mem_responder: RTL and testbench

Byte-wide memory responder serving the datapath's memory interface. It services single-byte reads and writes, and four-byte instruction fetches. It drives memdata and the one-hot irwrite strobes that the datapath consumes, so the instruction register loads without controller sequencing. It sits between the datapath (adr, writedata) and the byte RAM, and inserts a configurable number of wait states per byte.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_array.sv | 37 +++
 rtl/mem_responder.sv | 167 ++++++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-wide memory responder.
package mem_pkg;

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_FETCH_NEXT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_FETCH
    } op_e;

    function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Byte RAM: one synchronous write port and one registered read port with enable.
// The read register holds its value between enabled reads and clears on reset.
module mem_array #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter string       INIT_FILE = ""
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: single-byte read/write and four-byte little-endian fetch
// with WAIT wait states per byte, driving memdata and one-hot irwrite strobes.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WAIT      = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              fetch,
    output logic [DATA_W-1:0] memdata,
    output logic              ready,
    output logic [3:0]        irwrite,
    output logic              busy,
    output logic              done
);

    state_e              r_state;
    state_e              w_state_nxt;
    op_e                 r_op;
    op_e                 w_req_op;
    op_e                 w_acc_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [WAIT_W-1:0]   r_cnt;
    logic [WAIT_W-1:0]   w_cnt_nxt;
    logic [1:0]          r_idx;
    logic [1:0]          w_idx_nxt;
    logic                w_req;
    logic                w_accept;
    logic                w_enter_resp;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_data;
    logic                w_we;
    logic                w_re;
    logic [DATA_W-1:0]   w_rdata;

    always_comb begin
        w_req = fetch | memwrite | memread;
        if (fetch) begin
            w_req_op = OP_FETCH;
        end else if (memwrite) begin
            w_req_op = OP_WR;
        end else begin
            w_req_op = OP_RD;
        end
    end

    // The RAM port is driven on the edge that enters RESP, so in IDLE with
    // WAIT=0 the raw request must be used before it lands in r_addr/r_data.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        w_acc_op     = r_op;
        w_acc_addr   = r_addr + ADDR_W'(r_idx);
        w_acc_data   = r_data;

        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_accept   = 1'b1;
                    w_acc_op   = w_req_op;
                    w_acc_addr = adr;
                    w_acc_data = writedata;
                    w_idx_nxt  = 2'd0;
                    if (WAIT == 0) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = WAIT_W'(WAIT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_RESP: begin
                if (r_op == OP_FETCH) begin
                    if (r_idx == 2'd3) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_FETCH_NEXT;
                        w_idx_nxt   = r_idx + 2'd1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH_NEXT: begin
                if (WAIT == 0) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = WAIT_W'(WAIT - 1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            if (w_accept) begin
                r_op   <= w_req_op;
                r_addr <= adr;
                r_data <= writedata;
            end
        end
    end

    assign w_we = w_enter_resp && (w_acc_op == OP_WR);
    assign w_re = w_enter_resp && (w_acc_op != OP_WR);

    mem_array #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_mem_array (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_we),
        .i_waddr (w_acc_addr),
        .i_wdata (w_acc_data),
        .i_re    (w_re),
        .i_raddr (w_acc_addr),
        .o_rdata (w_rdata)
    );

    assign memdata = w_rdata;
    assign ready   = (r_state == S_RESP);
    assign irwrite = (r_state == S_RESP && r_op == OP_FETCH) ? idx_onehot(r_idx) : 4'b0000;
    assign busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: WAIT=1 instance via queue/monitor, plus
// a WAIT=0 instance for single-cycle latency checks.
module tb_mem_responder;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] irw;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] adr, writedata;
    logic       memread, memwrite, fetch;
    logic [7:0] memdata;
    logic       ready, busy, done;
    logic [3:0] irwrite;

    logic [7:0] z_adr, z_writedata;
    logic       z_memread, z_memwrite, z_fetch;
    logic [7:0] z_memdata;
    logic       z_ready, z_busy, z_done;
    logic [3:0] z_irwrite;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          rdy_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] instr = '0;
    logic [7:0]  hold = 8'h00;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT(1), .INIT_FILE("")) u_dut (
        .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
        .memread(memread), .memwrite(memwrite), .fetch(fetch),
        .memdata(memdata), .ready(ready), .irwrite(irwrite), .busy(busy), .done(done)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .reset(reset), .adr(z_adr), .writedata(z_writedata),
        .memread(z_memread), .memwrite(z_memwrite), .fetch(z_fetch),
        .memdata(z_memdata), .ready(z_ready), .irwrite(z_irwrite), .busy(z_busy),
        .done(z_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every ready pulse pops one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (ready) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_ready: actual=ready with empty scoreboard required=none");
            end else begin
                e = sb.pop_front();
                chk("resp_memdata", {24'h0, memdata}, {24'h0, e.data});
                chk("resp_irwrite", {28'h0, irwrite}, {28'h0, e.irw});
                chk("resp_busy", {31'h0, busy}, 32'd1);
            end
            for (int k = 0; k < 4; k++) begin
                if (irwrite[k]) instr[8*k +: 8] = memdata;
            end
        end
        if (done) done_cnt++;
    end

    task automatic push(input logic [7:0] d, input logic [3:0] irw);
        exp_t e;
        e.data = d;
        e.irw  = irw;
        sb.push_back(e);
    endtask

    task automatic req(input logic f, input logic w, input logic r,
                       input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        fetch = f; memwrite = w; memread = r; adr = a; writedata = d;
        @(negedge clk);
        fetch = 1'b0; memwrite = 1'b0; memread = 1'b0;
        chk("busy_after_accept", {31'h0, busy}, 32'd1);
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        #1;
        while ((sb.size() != 0 || busy || done) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: actual=still busy after %0d cycles required=idle", budget);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        push(hold, 4'b0000);
        req(1'b0, 1'b1, 1'b0, a, d);
        wait_quiet(30);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d);
        push(d, 4'b0000);
        hold = d;
        req(1'b0, 1'b0, 1'b1, a, 8'h00);
        wait_quiet(30);
    endtask

    initial begin
        int r0, d0, busy_low, n;
        reset = 1'b0;
        adr = '0; writedata = '0; memread = 0; memwrite = 0; fetch = 0;
        z_adr = '0; z_writedata = '0; z_memread = 0; z_memwrite = 0; z_fetch = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_memdata", {24'h0, memdata}, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_irwrite", {28'h0, irwrite}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);

        do_write(8'h00, 8'h20);
        do_write(8'h01, 8'h08);
        do_write(8'h02, 8'h43);
        do_write(8'h03, 8'h00);
        do_write(8'h11, 8'h00);

        // Fetch from 00 with a read issued mid-fetch that must be dropped.
        push(8'h20, 4'b0001); push(8'h08, 4'b0010);
        push(8'h43, 4'b0100); push(8'h00, 4'b1000);
        hold = 8'h00;
        instr = '0;
        r0 = rdy_cnt;
        d0 = done_cnt;
        req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        memread = 1'b1; adr = 8'h10;
        @(negedge clk);
        memread = 1'b0;
        busy_low = 0;
        n = 0;
        while (n < 40) begin
            #1;
            if (!busy) busy_low++;
            if (rdy_cnt - r0 >= 4) break;
            @(negedge clk);
            n++;
        end
        wait_quiet(20);
        chk("fetch_busy_low_cycles", busy_low, 0);
        chk("fetch_ready_count", rdy_cnt - r0, 4);
        chk("fetch_done_count", done_cnt - d0, 1);
        chk("fetch_instr", instr, 32'h00430820);

        do_write(8'h10, 8'hA5);
        push(8'hA5, 4'b0000);
        hold = 8'hA5;
        req(1'b0, 1'b0, 1'b1, 8'h10, 8'h00);
        chk("lat_wait1_early", {31'h0, ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("lat_wait1_ready", {31'h0, ready}, 32'd1);
        wait_quiet(30);
        do_read(8'h11, 8'h00);

        // All three request lines together at FE: only the fetch runs, wrapping.
        do_write(8'hFE, 8'h11);
        do_write(8'hFF, 8'h22);
        push(8'h11, 4'b0001); push(8'h22, 4'b0010);
        push(8'h20, 4'b0100); push(8'h08, 4'b1000);
        hold = 8'h08;
        instr = '0;
        d0 = done_cnt;
        req(1'b1, 1'b1, 1'b1, 8'hFE, 8'h99);
        wait_quiet(60);
        chk("wrap_instr", instr, 32'h082011_22 >> 0 == 0 ? 32'h0 : 32'h08202211);
        chk("wrap_done_count", done_cnt - d0, 1);
        do_read(8'hFE, 8'h11);

        // WAIT=0 instance: response one cycle after acceptance.
        @(negedge clk);
        z_memwrite = 1'b1; z_adr = 8'h20; z_writedata = 8'h3C;
        @(negedge clk);
        z_memwrite = 1'b0;
        chk("w0_write_ready", {31'h0, z_ready}, 32'd1);
        @(negedge clk);
        chk("w0_write_ready_clear", {31'h0, z_ready}, 32'd0);
        chk("w0_idle_busy", {31'h0, z_busy}, 32'd0);
        z_memread = 1'b1; z_adr = 8'h20;
        @(negedge clk);
        z_memread = 1'b0;
        chk("w0_read_ready", {31'h0, z_ready}, 32'd1);
        chk("w0_read_data", {24'h0, z_memdata}, 32'h3C);
        @(negedge clk);
        chk("w0_read_ready_clear", {31'h0, z_ready}, 32'd0);
        chk("w0_data_hold", {24'h0, z_memdata}, 32'h3C);

        // Reset during WAIT of a write: aborted, outputs clear immediately.
        @(negedge clk);
        memwrite = 1'b1; adr = 8'h10; writedata = 8'h5A;
        @(negedge clk);
        memwrite = 1'b0;
        r0 = rdy_cnt;
        adr = 8'($urandom); writedata = 8'($urandom);
        fetch = 1'($urandom); memwrite = 1'($urandom); memread = 1'($urandom);
        z_adr = 8'($urandom); z_fetch = 1'($urandom); z_memread = 1'($urandom);
        reset = 1'b0;
        #1;
        chk("arst_memdata", {24'h0, memdata}, 32'h0);
        chk("arst_ready", {31'h0, ready}, 32'h0);
        chk("arst_irwrite", {28'h0, irwrite}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_done", {31'h0, done}, 32'h0);
        chk("arst_w0_memdata", {24'h0, z_memdata}, 32'h0);
        #1;
        fetch = 0; memwrite = 0; memread = 0; z_fetch = 0; z_memread = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_no_ready", rdy_cnt - r0, 0);
        hold = 8'h00;
        do_read(8'h10, 8'hA5);

        wait_quiet(20);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
